// File: rtl/decode_packet.sv
// USB receive-path packet decoder: validates the PID, classifies handshake/token/data
// packets, checks CRC5/CRC16 and forwards data payloads with the CRC16 bytes stripped.
module decode_packet (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o,
  input  logic        rx_tlast_i,
  input  logic [7:0]  rx_tdata_i,
  output logic        hsk_recv_o,
  output logic [1:0]  hsk_type_o,
  output logic        tok_recv_o,
  output logic [1:0]  tok_type_o,
  output logic [15:0] tok_data_o,
  output logic [1:0]  dat_type_o,
  output logic        out_tvalid_o,
  output logic        out_tlast_o,
  output logic [7:0]  out_tdata_o,
  output logic        dat_done_o,
  output logic        dat_crc_ok_o,
  output logic        err_o
);

  typedef enum logic [2:0] {IDLE, TOK1, TOK2, DAT, DROP} state_t;

  // USB CRC5 (x^5+x^2+1), bits fed LSB first; result packed as it sits in token bits [15:11].
  function automatic logic [4:0] crc5(input logic [10:0] d);
    logic [4:0] r;
    logic [4:0] res;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (d[i] ^ r[4]) r = {r[3:0], 1'b0} ^ 5'b00101;
      else             r = {r[3:0], 1'b0};
    end
    for (int i = 0; i < 5; i++) res[i] = ~r[4-i];
    return res;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (b[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Complemented, bit-reversed register: the value {hi, lo} carried on the wire.
  function automatic logic [15:0] crc16_wire(input logic [15:0] c);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = ~c[15-i];
    return w;
  endfunction

  state_t      state_reg;
  logic [1:0]  occ_reg;
  logic [7:0]  b0_reg;
  logic [7:0]  b1_reg;
  logic [15:0] crc_reg;
  logic        pid_ok;
  logic [15:0] crc_fin;
  logic [15:0] crc_wire;
  logic [4:0]  crc5_calc;

  assign pid_ok    = (rx_tdata_i[7:4] == ~rx_tdata_i[3:0]);
  assign crc_fin   = (occ_reg == 2'd2) ? crc16_byte(crc_reg, b1_reg) : crc_reg;
  assign crc_wire  = crc16_wire(crc_fin);
  assign crc5_calc = crc5({rx_tdata_i[2:0], tok_data_o[7:0]});

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      occ_reg      <= 2'd0;
      b0_reg       <= 8'd0;
      b1_reg       <= 8'd0;
      crc_reg      <= 16'hFFFF;
      rx_tready_o  <= 1'b0;
      hsk_recv_o   <= 1'b0;
      hsk_type_o   <= 2'd0;
      tok_recv_o   <= 1'b0;
      tok_type_o   <= 2'd0;
      tok_data_o   <= 16'd0;
      dat_type_o   <= 2'd0;
      out_tvalid_o <= 1'b0;
      out_tlast_o  <= 1'b0;
      out_tdata_o  <= 8'd0;
      dat_done_o   <= 1'b0;
      dat_crc_ok_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      rx_tready_o  <= 1'b1;
      hsk_recv_o   <= 1'b0;
      tok_recv_o   <= 1'b0;
      out_tvalid_o <= 1'b0;
      out_tlast_o  <= 1'b0;
      dat_done_o   <= 1'b0;
      dat_crc_ok_o <= 1'b0;
      err_o        <= 1'b0;
      if (rx_tvalid_i) begin
        case (state_reg)
          IDLE: begin
            if (!pid_ok) begin
              err_o <= 1'b1;
              if (!rx_tlast_i) state_reg <= DROP;
            end else begin
              case (rx_tdata_i[1:0])
                2'b10: begin
                  if (rx_tlast_i) begin
                    hsk_recv_o <= 1'b1;
                    hsk_type_o <= rx_tdata_i[3:2];
                  end else begin
                    err_o     <= 1'b1;
                    state_reg <= DROP;
                  end
                end
                2'b01: begin
                  if (rx_tlast_i) err_o <= 1'b1;
                  else begin
                    tok_type_o <= rx_tdata_i[3:2];
                    state_reg  <= TOK1;
                  end
                end
                2'b11: begin
                  if (rx_tlast_i) err_o <= 1'b1;
                  else begin
                    dat_type_o <= rx_tdata_i[3:2];
                    occ_reg    <= 2'd0;
                    crc_reg    <= 16'hFFFF;
                    state_reg  <= DAT;
                  end
                end
                default: begin
                  err_o <= 1'b1;
                  if (!rx_tlast_i) state_reg <= DROP;
                end
              endcase
            end
          end
          TOK1: begin
            tok_data_o[7:0] <= rx_tdata_i;
            if (rx_tlast_i) begin
              err_o     <= 1'b1;
              state_reg <= IDLE;
            end else begin
              state_reg <= TOK2;
            end
          end
          TOK2: begin
            tok_data_o[15:8] <= rx_tdata_i;
            if (rx_tlast_i) begin
              if (crc5_calc == rx_tdata_i[7:3]) tok_recv_o <= 1'b1;
              else                              err_o      <= 1'b1;
              state_reg <= IDLE;
            end else begin
              err_o     <= 1'b1;
              state_reg <= DROP;
            end
          end
          DAT: begin
            // The newest two bytes stay buffered: they may turn out to be the CRC16.
            if (!rx_tlast_i) begin
              if (occ_reg == 2'd2) begin
                out_tvalid_o <= 1'b1;
                out_tdata_o  <= b1_reg;
                crc_reg      <= crc16_byte(crc_reg, b1_reg);
              end else begin
                occ_reg <= occ_reg + 2'd1;
              end
              b1_reg <= b0_reg;
              b0_reg <= rx_tdata_i;
            end else begin
              if (occ_reg == 2'd2) begin
                out_tvalid_o <= 1'b1;
                out_tlast_o  <= 1'b1;
                out_tdata_o  <= b1_reg;
              end
              dat_done_o   <= 1'b1;
              dat_crc_ok_o <= (occ_reg != 2'd0) && ({rx_tdata_i, b0_reg} == crc_wire);
              occ_reg      <= 2'd0;
              state_reg    <= IDLE;
            end
          end
          DROP: begin
            if (rx_tlast_i) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
